control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired control sequencer for the Mano basic computer; drives the control inputs of the datapath.
//  Runs a 3-bit sequence counter (T0..T6) through fetch, decode, indirect and execute.
//  Decodes the IR and the datapath status flags into per-cycle register write/inc/clear strobes.
//  Also drives ALU select, common-bus select and memory strobes.
// PARAMETERS
//  ADDR_W   12  address width; informational, no control output depends on it
//  WORD_W   16  instruction/data word width
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset_n       in   1   synchronous, active-low reset
//  ir            in   16  current IR contents from datapath
//  ac_zero       in   1   AC == 0
//  ac_sign       in   1   AC[15]
//  dr_zero       in   1   DR == 0
//  e_flag        in   1   E register
//  sel           out  3   ALU operation code (mano_pkg ALU_*)
//  bus_sel       out  3   common-bus source: 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//  mem_read      out  1   memory read onto bus
//  mem_write     out  1   memory write M[AR] <- bus
//  AR_write, AR_increment, AR_clear  out 1 each
//  PC_write, PC_increment, PC_clear  out 1 each
//  DR_write, DR_increment, DR_clear  out 1 each
//  AC_write, AC_increment, AC_clear  out 1 each
//  IR_write, TR_write, TR_increment, TR_clear, OUTR_write  out 1 each
//  E_clear, E_complement  out 1 each
//  sc            out  3   sequence counter value (Tn index), debug
//  halted        out  1   HLT executed
// BEHAVIOUR
//  - State: sc[2:0], halted. Outputs are combinational from sc, halted and ir; effects occur at the edge ending Tn.
//  - reset_n low at an edge: sc<=0, halted<=0. While reset_n low, all control outputs forced 0; sel=0, bus_sel=0.
//  - Reset mid-instruction aborts it; no partial completion.
//  - Decode: D = ir[14:12], I = ir[15]. sc increments each cycle unless cleared (SC<-0) below.
//  - T0: bus_sel=PC, AR_write.
//  - T1: bus_sel=MEM, mem_read, IR_write, PC_increment.
//  - T2: bus_sel=IR, AR_write (AR<-ir[11:0]).
//  - T3, D!=7: I=1: bus_sel=MEM, mem_read, AR_write. I=0: no strobes.
//  - T3, D=7, I=0 (register ref, same cycle, then SC<-0):
//    CLA(b11) AC_clear; CLE(b10) E_clear; CMA(b9) sel=ALU_CMA,AC_write; CME(b8) E_complement.
//    CIR(b7) sel=ALU_SHR,AC_write; CIL(b6) sel=ALU_SHL,AC_write; INC(b5) AC_increment.
//    SPA(b4) !ac_sign; SNA(b3) ac_sign; SZA(b2) ac_zero; SZE(b1) !e_flag. Skip conditions OR-ed into one PC_increment.
//    HLT(b0) halted<=1.
//  - Multiple AC-modifying bits: only the highest priority acts (CLA>CMA>CIR>CIL>INC); E bits and skips always act.
//  - T3, D=7, I=1 (I/O): OUT (b10) bus_sel=AC, OUTR_write; other bits no-op; SC<-0.
//  - T4..T6 memory reference (D):
//    AND/ADD/LDA (0/1/2): T4 bus_sel=MEM, mem_read, DR_write; T5 sel=ALU_AND/ADD/LOAD, AC_write, SC<-0.
//    STA (3): T4 bus_sel=AC, mem_write, SC<-0.
//    BUN (4): T4 bus_sel=AR, PC_write, SC<-0.
//    BSA (5): T4 bus_sel=PC, mem_write, AR_increment; T5 bus_sel=AR, PC_write, SC<-0.
//    ISZ (6): T4 mem_read, bus_sel=MEM, DR_write; T5 DR_increment; T6 bus_sel=DR, mem_write, PC_increment iff dr_zero, SC<-0.
//  - halted=1: sc frozen, all control outputs 0 until reset_n low; halted takes effect from the cycle after T3.
//  - sc never exceeds 6; reaching 7 is illegal and treated as SC<-0 with no strobes.
//  - TR_write, TR_increment, TR_clear, DR_clear, AR_clear, PC_clear held 0 (reserved for interrupt cycle).
// STRUCTURE
//  - mano_pkg: opcode D codes, register-ref/IO bit indices, ALU_* codes (AND 0, ADD 1, LOAD 2, CMA 3, SHR 4, SHL 5), BUS_* codes.
//  - Sub-module seq_counter: 3-bit counter with sync active-low reset, clear, increment, hold.
//  - Remaining logic: one combinational decode block.
// TESTING
//  - reset_n low 2 cycles during T4 of LDA -> sc=0, all strobes 0; release -> T0 bus_sel=2, AR_write=1.
//  - ir=0x2005 (LDA direct) -> T4 bus_sel=7, mem_read, DR_write; T5 sel=2, AC_write; next cycle sc=0.
//  - ir=0x9010 (ADD indirect) -> T3 bus_sel=7, mem_read, AR_write; T5 sel=1, AC_write.
//  - ir=0x6020 (ISZ), dr_zero=1 at T6 -> bus_sel=3, mem_write, PC_increment; dr_zero=0 -> PC_increment=0.
//  - ir=0x7004 (SZA), ac_zero=1 -> T3 PC_increment=1; ir=0x7001 (HLT) -> halted=1, sc frozen, strobes 0 for 10 cycles.
//  - ir=0x5030 (BSA) -> T4 bus_sel=2, mem_write, AR_increment; T5 bus_sel=1, PC_write; ir=0x7A00 -> AC_clear only, no sel write.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic computer control path: opcodes, instruction bit
// positions, ALU operation codes, common-bus sources and sequence-counter states.
package mano_pkg;

  localparam logic [2:0] D_AND    = 3'd0;
  localparam logic [2:0] D_ADD    = 3'd1;
  localparam logic [2:0] D_LDA    = 3'd2;
  localparam logic [2:0] D_STA    = 3'd3;
  localparam logic [2:0] D_BUN    = 3'd4;
  localparam logic [2:0] D_BSA    = 3'd5;
  localparam logic [2:0] D_ISZ    = 3'd6;
  localparam logic [2:0] D_REG_IO = 3'd7;

  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;
  localparam int unsigned IO_OUT = 10;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_LOAD = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_SHR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;

endpackage

// File: rtl/seq_counter.sv
// 3-bit timing sequence counter: synchronous active-low reset, then clear, then
// increment, otherwise hold.
module seq_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [2:0] o_count
);

  logic [2:0] r_count;

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values, free of race order.
    if (!reset_n)     r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc)   r_count <= r_count + 3'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the Mano basic computer: decodes IR, status flags and
// the current timing step into per-cycle datapath strobes.
module control_unit
  import mano_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] ir,
  input  logic              ac_zero,
  input  logic              ac_sign,
  input  logic              dr_zero,
  input  logic              e_flag,
  output logic [2:0]        sel,
  output logic [2:0]        bus_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              AR_write,
  output logic              AR_increment,
  output logic              AR_clear,
  output logic              PC_write,
  output logic              PC_increment,
  output logic              PC_clear,
  output logic              DR_write,
  output logic              DR_increment,
  output logic              DR_clear,
  output logic              AC_write,
  output logic              AC_increment,
  output logic              AC_clear,
  output logic              IR_write,
  output logic              TR_write,
  output logic              TR_increment,
  output logic              TR_clear,
  output logic              OUTR_write,
  output logic              E_clear,
  output logic              E_complement,
  output logic [2:0]        sc,
  output logic              halted
);

  logic              w_i;
  logic [2:0]        w_d;
  logic [ADDR_W-1:0] w_ref;
  logic [2:0]        w_sc;
  logic              w_sc_clear;
  logic              w_sc_inc;
  logic              w_set_halt;
  logic              r_halted;

  assign w_i   = ir[WORD_W-1];
  assign w_d   = ir[WORD_W-2 -: 3];
  assign w_ref = ir[ADDR_W-1:0];

  seq_counter u_seq_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_sc_clear),
    .i_inc   (w_sc_inc),
    .o_count (w_sc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)        r_halted <= 1'b0;
    else if (w_set_halt) r_halted <= 1'b1;
  end

  assign sc     = w_sc;
  assign halted = r_halted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    sel          = ALU_AND;
    bus_sel      = BUS_NONE;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    AR_write     = 1'b0;
    AR_increment = 1'b0;
    AR_clear     = 1'b0;
    PC_write     = 1'b0;
    PC_increment = 1'b0;
    PC_clear     = 1'b0;
    DR_write     = 1'b0;
    DR_increment = 1'b0;
    DR_clear     = 1'b0;
    AC_write     = 1'b0;
    AC_increment = 1'b0;
    AC_clear     = 1'b0;
    IR_write     = 1'b0;
    TR_write     = 1'b0;
    TR_increment = 1'b0;
    TR_clear     = 1'b0;
    OUTR_write   = 1'b0;
    E_clear      = 1'b0;
    E_complement = 1'b0;
    w_sc_clear   = 1'b0;
    w_sc_inc     = 1'b0;
    w_set_halt   = 1'b0;

    if (reset_n && !r_halted) begin
      w_sc_inc = 1'b1;
      case (w_sc)
        T0: begin
          bus_sel  = BUS_PC;
          AR_write = 1'b1;
        end
        T1: begin
          bus_sel      = BUS_MEM;
          mem_read     = 1'b1;
          IR_write     = 1'b1;
          PC_increment = 1'b1;
        end
        T2: begin
          bus_sel  = BUS_IR;
          AR_write = 1'b1;
        end
        T3: begin
          if (w_d != D_REG_IO) begin
            if (w_i) begin
              bus_sel  = BUS_MEM;
              mem_read = 1'b1;
              AR_write = 1'b1;
            end
          end else if (!w_i) begin
            // Only one AC source may act; E updates and skips are independent.
            if (w_ref[RR_CLA])      AC_clear = 1'b1;
            else if (w_ref[RR_CMA]) begin sel = ALU_CMA; AC_write = 1'b1; end
            else if (w_ref[RR_CIR]) begin sel = ALU_SHR; AC_write = 1'b1; end
            else if (w_ref[RR_CIL]) begin sel = ALU_SHL; AC_write = 1'b1; end
            else if (w_ref[RR_INC]) AC_increment = 1'b1;
            E_clear      = w_ref[RR_CLE];
            E_complement = w_ref[RR_CME];
            PC_increment = (w_ref[RR_SPA] && !ac_sign) || (w_ref[RR_SNA] && ac_sign) ||
                           (w_ref[RR_SZA] && ac_zero)  || (w_ref[RR_SZE] && !e_flag);
            w_set_halt   = w_ref[RR_HLT];
            w_sc_clear   = 1'b1;
          end else begin
            if (w_ref[IO_OUT]) begin
              bus_sel    = BUS_AC;
              OUTR_write = 1'b1;
            end
            w_sc_clear = 1'b1;
          end
        end
        T4: begin
          case (w_d)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              bus_sel  = BUS_MEM;
              mem_read = 1'b1;
              DR_write = 1'b1;
            end
            D_STA: begin
              bus_sel    = BUS_AC;
              mem_write  = 1'b1;
              w_sc_clear = 1'b1;
            end
            D_BUN: begin
              bus_sel    = BUS_AR;
              PC_write   = 1'b1;
              w_sc_clear = 1'b1;
            end
            D_BSA: begin
              bus_sel      = BUS_PC;
              mem_write    = 1'b1;
              AR_increment = 1'b1;
            end
            default: w_sc_clear = 1'b1;
          endcase
        end
        T5: begin
          case (w_d)
            D_AND: begin sel = ALU_AND;  AC_write = 1'b1; w_sc_clear = 1'b1; end
            D_ADD: begin sel = ALU_ADD;  AC_write = 1'b1; w_sc_clear = 1'b1; end
            D_LDA: begin sel = ALU_LOAD; AC_write = 1'b1; w_sc_clear = 1'b1; end
            D_BSA: begin
              bus_sel    = BUS_AR;
              PC_write   = 1'b1;
              w_sc_clear = 1'b1;
            end
            D_ISZ:   DR_increment = 1'b1;
            default: w_sc_clear = 1'b1;
          endcase
        end
        T6: begin
          if (w_d == D_ISZ) begin
            bus_sel      = BUS_DR;
            mem_write    = 1'b1;
            PC_increment = dr_zero;
          end
          w_sc_clear = 1'b1;
        end
        default: begin
          w_sc_inc   = 1'b0;
          w_sc_clear = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: instructions are expanded into expected
// micro-cycle lists; a negedge monitor pops and compares each presented cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ir;
  logic        ac_zero, ac_sign, dr_zero, e_flag;
  logic [2:0]  sel, bus_sel, sc;
  logic        mem_read, mem_write;
  logic        AR_write, AR_increment, AR_clear;
  logic        PC_write, PC_increment, PC_clear;
  logic        DR_write, DR_increment, DR_clear;
  logic        AC_write, AC_increment, AC_clear;
  logic        IR_write, TR_write, TR_increment, TR_clear, OUTR_write;
  logic        E_clear, E_complement, halted;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .ir(ir),
    .ac_zero(ac_zero), .ac_sign(ac_sign), .dr_zero(dr_zero), .e_flag(e_flag),
    .sel(sel), .bus_sel(bus_sel), .mem_read(mem_read), .mem_write(mem_write),
    .AR_write(AR_write), .AR_increment(AR_increment), .AR_clear(AR_clear),
    .PC_write(PC_write), .PC_increment(PC_increment), .PC_clear(PC_clear),
    .DR_write(DR_write), .DR_increment(DR_increment), .DR_clear(DR_clear),
    .AC_write(AC_write), .AC_increment(AC_increment), .AC_clear(AC_clear),
    .IR_write(IR_write), .TR_write(TR_write), .TR_increment(TR_increment),
    .TR_clear(TR_clear), .OUTR_write(OUTR_write),
    .E_clear(E_clear), .E_complement(E_complement),
    .sc(sc), .halted(halted)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] bus_sel;
    logic mem_read, mem_write;
    logic ar_w, ar_i, ar_c, pc_w, pc_i, pc_c, dr_w, dr_i, dr_c;
    logic ac_w, ac_i, ac_c, ir_w, tr_w, tr_i, tr_c, outr_w, e_c, e_cm;
    logic [2:0] sc;
    logic halted;
  } ctl_t;

  ctl_t  exp_q[$];
  string tag_q[$];
  ctl_t  prog_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  logic [2:0] m_sc;
  logic       m_halted;

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents one control word per cycle.
  initial begin
    ctl_t  act;
    ctl_t  exp;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = '{sel, bus_sel, mem_read, mem_write,
                AR_write, AR_increment, AR_clear, PC_write, PC_increment, PC_clear,
                DR_write, DR_increment, DR_clear, AC_write, AC_increment, AC_clear,
                IR_write, TR_write, TR_increment, TR_clear, OUTR_write,
                E_clear, E_complement, sc, halted};
        check(tag, act, exp);
      end
    end
  end

  function automatic ctl_t cyc(input logic [2:0] t, input logic h);
    ctl_t c;
    c        = '0;
    c.sc     = t;
    c.halted = h;
    return c;
  endfunction

  // Reference model: an instruction becomes its list of micro-cycles.
  task automatic build(input logic [15:0] x, input logic az, input logic asg,
                       input logic dz, input logic ef);
    ctl_t c;
    logic [2:0] d;
    logic i;
    d = x[14:12];
    i = x[15];
    prog_q.delete();
    c = cyc(0, 0); c.bus_sel = 2; c.ar_w = 1; prog_q.push_back(c);
    c = cyc(1, 0); c.bus_sel = 7; c.mem_read = 1; c.ir_w = 1; c.pc_i = 1; prog_q.push_back(c);
    c = cyc(2, 0); c.bus_sel = 5; c.ar_w = 1; prog_q.push_back(c);
    c = cyc(3, 0);
    if (d == 7 && !i) begin
      if (x[11])     c.ac_c = 1;
      else if (x[9]) begin c.sel = 3; c.ac_w = 1; end
      else if (x[7]) begin c.sel = 4; c.ac_w = 1; end
      else if (x[6]) begin c.sel = 5; c.ac_w = 1; end
      else if (x[5]) c.ac_i = 1;
      c.e_c  = x[10];
      c.e_cm = x[8];
      c.pc_i = (x[4] & ~asg) | (x[3] & asg) | (x[2] & az) | (x[1] & ~ef);
      prog_q.push_back(c);
      return;
    end
    if (d == 7) begin
      if (x[10]) begin c.bus_sel = 4; c.outr_w = 1; end
      prog_q.push_back(c);
      return;
    end
    if (i) begin c.bus_sel = 7; c.mem_read = 1; c.ar_w = 1; end
    prog_q.push_back(c);
    case (d)
      0, 1, 2: begin
        c = cyc(4, 0); c.bus_sel = 7; c.mem_read = 1; c.dr_w = 1; prog_q.push_back(c);
        c = cyc(5, 0); c.ac_w = 1;
        c.sel = (d == 0) ? 3'd0 : (d == 1) ? 3'd1 : 3'd2;
        prog_q.push_back(c);
      end
      3: begin c = cyc(4, 0); c.bus_sel = 4; c.mem_write = 1; prog_q.push_back(c); end
      4: begin c = cyc(4, 0); c.bus_sel = 1; c.pc_w = 1; prog_q.push_back(c); end
      5: begin
        c = cyc(4, 0); c.bus_sel = 2; c.mem_write = 1; c.ar_i = 1; prog_q.push_back(c);
        c = cyc(5, 0); c.bus_sel = 1; c.pc_w = 1; prog_q.push_back(c);
      end
      default: begin
        c = cyc(4, 0); c.bus_sel = 7; c.mem_read = 1; c.dr_w = 1; prog_q.push_back(c);
        c = cyc(5, 0); c.dr_i = 1; prog_q.push_back(c);
        c = cyc(6, 0); c.bus_sel = 3; c.mem_write = 1; c.pc_i = dz; prog_q.push_back(c);
      end
    endcase
  endtask

  task automatic drive_cycle(input ctl_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Runs at most max_cycles micro-cycles of an instruction (<=0 means all of it).
  task automatic run_instr(input logic [15:0] x, input logic az, input logic asg,
                           input logic dz, input logic ef, input int max_cycles);
    int n;
    ir = x; ac_zero = az; ac_sign = asg; dr_zero = dz; e_flag = ef;
    build(x, az, asg, dz, ef);
    n = (max_cycles > 0 && max_cycles < prog_q.size()) ? max_cycles : prog_q.size();
    for (int k = 0; k < n; k++)
      drive_cycle(prog_q[k], $sformatf("ir=%h T%0d", x, prog_q[k].sc));
    if (n == prog_q.size()) begin
      m_sc = 0;
      if (x[15:12] == 4'h7 && x[0]) m_halted = 1;
    end else begin
      m_sc = 3'(n);
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 0;
    for (int k = 0; k < cycles; k++) begin
      drive_cycle((k == 0) ? cyc(m_sc, m_halted) : cyc(0, 0), $sformatf("reset c%0d", k));
    end
    m_sc = 0;
    m_halted = 0;
    reset_n = 1;
  endtask

  initial begin
    logic [15:0] x;
    reset_n = 0; ir = '0; ac_zero = 0; ac_sign = 0; dr_zero = 0; e_flag = 0;
    repeat (2) @(posedge clk);
    #1;
    m_sc = 0;
    m_halted = 0;
    apply_reset(1);

    run_instr(16'h2005, 0, 0, 0, 0, 0);
    run_instr(16'h9010, 0, 0, 0, 0, 0);
    run_instr(16'h6020, 0, 0, 1, 0, 0);
    run_instr(16'h6020, 0, 0, 0, 0, 0);
    run_instr(16'h7004, 1, 0, 0, 0, 0);
    run_instr(16'h7004, 0, 0, 0, 0, 0);
    run_instr(16'h5030, 0, 0, 0, 0, 0);
    run_instr(16'h7A00, 0, 0, 0, 0, 0);
    run_instr(16'h72E0, 0, 0, 0, 0, 0);
    run_instr(16'hF400, 0, 0, 0, 0, 0);
    run_instr(16'h3123, 0, 0, 0, 0, 0);
    run_instr(16'hC456, 0, 0, 0, 0, 0);

    // Abort LDA in T4 with a two-cycle reset, then restart from T0.
    run_instr(16'h2005, 0, 0, 0, 0, 4);
    apply_reset(2);
    run_instr(16'h2005, 0, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      x = 16'($urandom);
      if (x[14:12] == 3'd7 && !x[15]) x[0] = 1'b0;
      run_instr(x, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    run_instr(16'h7001, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      ir = 16'($urandom);
      drive_cycle(cyc(0, 1), $sformatf("halted c%0d", k));
    end
    apply_reset(1);
    run_instr(16'h4010, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
